// File: rtl/fb_sram_server.sv
//==============================================================================
// Module      : fb_sram_server
// Description : Responder side of the framebuffer read interface. Pixel read
//               requests from the VGA scan-out port are queued in a small FIFO
//               and served in order against an asynchronous 16-bit SRAM. Each
//               returned word is presented on framebufferData with a one-cycle
//               dataReady pulse. A lower-priority single-word write port for the
//               renderer is served only while the read FIFO is empty.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   BOARD_CLK          in   1   sole clock
//   RESET_N            in   1   asynchronous, active-low reset
//   queueRead          in   1   read request strobe, one request per cycle
//   framebufferAddress in   AW  word address sampled with queueRead
//   reqFull            out  1   request FIFO holds REQ_DEPTH entries
//   reqOverflow        out  1   sticky: a request arrived while full
//   dataReady          out  1   one-cycle pulse, framebufferData valid
//   framebufferData    out  DW  returned pixel word, held until next pulse
//   wrReq              in   1   write request, held high until wrAck
//   wrAddr             in   AW  write word address
//   wrData             in   DW  write word
//   wrAck              out  1   one-cycle pulse when the write completes
//   SRAM_ADDR          out  AW  SRAM address (registered)
//   SRAM_DQ_IN         in   DW  SRAM data bus, read side
//   SRAM_DQ_OUT        out  DW  SRAM data bus, drive value
//   SRAM_DQ_OE         out  1   drive SRAM_DQ_OUT onto the bus
//   SRAM_CE_N/OE_N/WE_N out 1   SRAM strobes (registered, active-low)
//   SRAM_UB_N/LB_N     out  1   byte enables, follow SRAM_CE_N
//==============================================================================
`default_nettype none

module fb_sram_server #(
    parameter int REQ_DEPTH = 4,
    parameter int READ_WAIT = 1,
    parameter int AW        = 20,
    parameter int DW        = 16
) (
    input  logic          BOARD_CLK,
    input  logic          RESET_N,
    input  logic          queueRead,
    input  logic [AW-1:0] framebufferAddress,
    output logic          reqFull,
    output logic          reqOverflow,
    output logic          dataReady,
    output logic [DW-1:0] framebufferData,
    input  logic          wrReq,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    output logic          wrAck,
    output logic [AW-1:0] SRAM_ADDR,
    input  logic [DW-1:0] SRAM_DQ_IN,
    output logic [DW-1:0] SRAM_DQ_OUT,
    output logic          SRAM_DQ_OE,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic          SRAM_UB_N,
    output logic          SRAM_LB_N
);

    localparam int PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(REQ_DEPTH);
    localparam logic [CW-1:0] WAIT_C  = CW'(READ_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [AW-1:0] fifo_mem [REQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [AW-1:0] head;
    logic [AW-1:0] next_head;
    logic          more_after_pop;

    assign fifo_empty = (count == '0);
    assign reqFull    = (count == DEPTH_C);
    // Room is judged on the pre-edge count; a pop on the same edge does not help.
    assign push       = queueRead && !reqFull;
    assign head       = fifo_mem[rd_ptr];

    // After popping the head, the next request is either already stored or is
    // the one being pushed on this very edge (bypass it straight to the SRAM).
    assign more_after_pop = (count > (PW+1)'(1)) || push;
    assign next_head      = (count > (PW+1)'(1)) ? fifo_mem[rd_ptr + PW'(1)]
                                                 : framebufferAddress;

    always_ff @(posedge BOARD_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= framebufferAddress;
        end
    end

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            reqOverflow <= 1'b0;
        end else if (queueRead && reqFull) begin
            reqOverflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // SRAM sequencer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] dq_out_n;
    logic          dq_oe_n;
    logic          ce_n_n;
    logic          oe_n_n;
    logic          we_n_n;
    logic          ready_n;
    logic          ack_n;
    logic [DW-1:0] data_n;

    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            cnt             <= '0;
            SRAM_ADDR       <= '0;
            SRAM_DQ_OUT     <= '0;
            SRAM_DQ_OE      <= 1'b0;
            SRAM_CE_N       <= 1'b1;
            SRAM_OE_N       <= 1'b1;
            SRAM_WE_N       <= 1'b1;
            dataReady       <= 1'b0;
            wrAck           <= 1'b0;
            framebufferData <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            SRAM_ADDR       <= addr_n;
            SRAM_DQ_OUT     <= dq_out_n;
            SRAM_DQ_OE      <= dq_oe_n;
            SRAM_CE_N       <= ce_n_n;
            SRAM_OE_N       <= oe_n_n;
            SRAM_WE_N       <= we_n_n;
            dataReady       <= ready_n;
            wrAck           <= ack_n;
            framebufferData <= data_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = SRAM_ADDR;
        dq_out_n = SRAM_DQ_OUT;
        dq_oe_n  = SRAM_DQ_OE;
        ce_n_n   = SRAM_CE_N;
        oe_n_n   = SRAM_OE_N;
        we_n_n   = SRAM_WE_N;
        ready_n  = 1'b0;
        ack_n    = 1'b0;
        data_n   = framebufferData;
        pop      = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = READ;
                    addr_n  = head;
                    ce_n_n  = 1'b0;
                    oe_n_n  = 1'b0;
                    cnt_n   = WAIT_C;
                end else if (wrReq && !wrAck) begin
                    // wrAck high means the requester has not yet seen the
                    // completion, so its still-high wrReq is the old request.
                    state_n  = WRITE;
                    addr_n   = wrAddr;
                    dq_out_n = wrData;
                    dq_oe_n  = 1'b1;
                    ce_n_n   = 1'b0;
                    we_n_n   = 1'b0;
                end
            end
            READ: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    pop     = 1'b1;
                    data_n  = SRAM_DQ_IN;
                    ready_n = 1'b1;
                    if (more_after_pop) begin
                        addr_n = next_head;
                        cnt_n  = WAIT_C;
                    end else begin
                        state_n = IDLE;
                        ce_n_n  = 1'b1;
                        oe_n_n  = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Release WE_N first; address and data stay put for hold time.
                state_n = WR_HOLD;
                we_n_n  = 1'b1;
            end
            WR_HOLD: begin
                state_n = IDLE;
                ack_n   = 1'b1;
                dq_oe_n = 1'b0;
                ce_n_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;

endmodule

`default_nettype wire
